// File: rtl/lfsr_rng_if.sv
// Valid/ready handshake carrying bounded random values from lfsr_rng to its consumer.
// The consumer also supplies the exclusive upper bound for the values it wants.
interface lfsr_rng_if #(
  parameter int OUT_W = 8
) ();
  logic [OUT_W-1:0] rnd;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [OUT_W-1:0] range_in;

  modport master (
    output rnd,
    output rnd_valid,
    input  rnd_ready,
    input  range_in
  );

  modport slave (
    input  rnd,
    input  rnd_valid,
    output rnd_ready,
    output range_in
  );
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with run-time seeding, lock-up recovery and
// bounded-range output using mask-and-reject sampling over a valid/ready handshake.
module lfsr_rng #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup,
  lfsr_rng_if.master       rng
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } fsm_t;

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  fsm_t             r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [OUT_W-1:0] r_rnd;
  logic             r_rnd_valid;
  logic             r_lockup;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic [OUT_W-1:0] w_rm1;
  logic [OUT_W-1:0] w_smear;
  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_cand;
  logic             w_accept;
  logic             w_xfer;
  logic             w_zero_state;

  assign w_fb         = ^(r_state & TAPS);
  assign w_next       = {r_state[WIDTH-2:0], w_fb};
  assign w_zero_state = (r_state == '0);

  // Smearing range-1 downward gives 2^ceil(log2(range))-1; range=1 yields mask 0.
  assign w_rm1 = rng.range_in - ONE;
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_smear
      assign w_smear[gi] = |w_rm1[OUT_W-1:gi];
    end
  endgenerate

  assign w_mask   = (rng.range_in == '0) ? '1 : w_smear;
  assign w_cand   = r_state[OUT_W-1:0] & w_mask;
  assign w_accept = (rng.range_in == '0) || (w_cand < rng.range_in);
  assign w_xfer   = r_rnd_valid & rng.rnd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SEED;
      r_rnd       <= '0;
      r_rnd_valid <= 1'b0;
      r_lockup    <= 1'b0;
      r_fsm       <= S_FILL;
    end else if (seed_load) begin
      // A zero seed would lock the register up, so it is replaced by SEED.
      r_state     <= (seed_in == '0) ? SEED : seed_in;
      r_lockup    <= (seed_in == '0);
      r_rnd_valid <= 1'b0;
      r_fsm       <= S_FILL;
    end else begin
      r_lockup <= w_zero_state;
      if (w_zero_state) begin
        r_state <= SEED;
      end else if (en) begin
        r_state <= w_next;
      end

      case (r_fsm)
        S_FILL: begin
          if (en && w_accept) begin
            r_rnd       <= w_cand;
            r_rnd_valid <= 1'b1;
            r_fsm       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_xfer) begin
            if (en && w_accept) begin
              r_rnd <= w_cand;
            end else begin
              r_rnd_valid <= 1'b0;
              r_fsm       <= S_FILL;
            end
          end
        end
        default: begin
          r_rnd_valid <= 1'b0;
          r_fsm       <= S_FILL;
        end
      endcase
    end
  end

  assign rng.rnd       = r_rnd;
  assign rng.rnd_valid = r_rnd_valid;
  assign state_out     = r_state;
  assign lockup        = r_lockup;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed testbench for lfsr_rng: reset, full/bounded range, backpressure,
// seed loading with lock-up recovery, enable freeze and asynchronous reset.
module tb_lfsr_rng;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [15:0] state_out;
  logic        lockup;

  int checks;
  int fails;

  // Hand-computed LFSR sequence from ACE1 with taps B400.
  logic [15:0] seq [0:16];

  lfsr_rng_if #(.OUT_W(8)) rng_if ();

  lfsr_rng #(
    .WIDTH (16),
    .TAPS  (16'hB400),
    .SEED  (16'hACE1),
    .OUT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state_out (state_out),
    .lockup    (lockup),
    .rng       (rng_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && rng_if.rnd_valid && rng_if.rnd_ready)
      $display("xfer rnd=%02h state=%04h range=%0d", rng_if.rnd, state_out, rng_if.range_in);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] range, input logic ready);
    rst_n            = 1'b0;
    en               = 1'b1;
    seed_load        = 1'b0;
    seed_in          = 16'h0000;
    rng_if.range_in  = range;
    rng_if.rnd_ready = ready;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(8'd0, 1'b1);
    checks++; if (rng_if.rnd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rng_if.rnd_valid); end
    checks++; if (rng_if.rnd !== 8'h00) begin fails++; $display("FAIL reset_rnd got=%02h exp=00", rng_if.rnd); end
    checks++; if (state_out !== 16'hACE1) begin fails++; $display("FAIL reset_state got=%04h exp=ACE1", state_out); end
    checks++; if (lockup !== 1'b0) begin fails++; $display("FAIL reset_lockup got=%b exp=0", lockup); end
  endtask

  task automatic test_full_range();
    logic [7:0] exp_rnd [0:3];
    exp_rnd[0] = 8'hE1; exp_rnd[1] = 8'hC3; exp_rnd[2] = 8'h87; exp_rnd[3] = 8'h0F;
    do_reset(8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (rng_if.rnd_valid !== 1'b1) begin fails++; $display("FAIL full_valid[%0d] got=%b exp=1", i, rng_if.rnd_valid); end
      checks++; if (rng_if.rnd !== exp_rnd[i]) begin fails++; $display("FAIL full_rnd[%0d] got=%02h exp=%02h", i, rng_if.rnd, exp_rnd[i]); end
      checks++; if (state_out !== seq[i+1]) begin fails++; $display("FAIL full_state[%0d] got=%04h exp=%04h", i, state_out, seq[i+1]); end
    end
  endtask

  task automatic test_bounded_range();
    do_reset(8'd3, 1'b1);
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'd1) begin fails++; $display("FAIL range3_first got=%b/%02h exp=1/01", rng_if.rnd_valid, rng_if.rnd); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rng_if.rnd_valid !== 1'b0) begin fails++; $display("FAIL range3_reject[%0d] got=%b exp=0", i, rng_if.rnd_valid); end
    end
    checks++; if (state_out !== 16'hCE1E) begin fails++; $display("FAIL range3_state got=%04h exp=CE1E", state_out); end
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'd2) begin fails++; $display("FAIL range3_second got=%b/%02h exp=1/02", rng_if.rnd_valid, rng_if.rnd); end
    // range_in=1 masks everything to zero, which is always accepted.
    rng_if.range_in = 8'd1;
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'd0) begin fails++; $display("FAIL range1 got=%b/%02h exp=1/00", rng_if.rnd_valid, rng_if.rnd); end
  endtask

  task automatic test_backpressure();
    do_reset(8'd0, 1'b0);
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'hE1) begin fails++; $display("FAIL bp_first got=%b/%02h exp=1/E1", rng_if.rnd_valid, rng_if.rnd); end
    rng_if.range_in = 8'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'hE1) begin fails++; $display("FAIL bp_hold[%0d] got=%b/%02h exp=1/E1", i, rng_if.rnd_valid, rng_if.rnd); end
      checks++; if (state_out !== seq[i+2]) begin fails++; $display("FAIL bp_state[%0d] got=%04h exp=%04h", i, state_out, seq[i+2]); end
    end
    rng_if.range_in  = 8'd0;
    rng_if.rnd_ready = 1'b1;
    step();
    rng_if.rnd_ready = 1'b0;
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'h22) begin fails++; $display("FAIL bp_release got=%b/%02h exp=1/22", rng_if.rnd_valid, rng_if.rnd); end
    checks++; if (state_out !== seq[12]) begin fails++; $display("FAIL bp_release_state got=%04h exp=%04h", state_out, seq[12]); end
  endtask

  task automatic test_seed_load();
    do_reset(8'd0, 1'b0);
    step();
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    step();
    seed_load = 1'b0;
    checks++; if (state_out !== 16'hACE1) begin fails++; $display("FAIL seed0_state got=%04h exp=ACE1", state_out); end
    checks++; if (lockup !== 1'b1) begin fails++; $display("FAIL seed0_lockup got=%b exp=1", lockup); end
    checks++; if (rng_if.rnd_valid !== 1'b0) begin fails++; $display("FAIL seed0_valid got=%b exp=0", rng_if.rnd_valid); end
    step();
    checks++; if (lockup !== 1'b0) begin fails++; $display("FAIL seed0_lockup_pulse got=%b exp=0", lockup); end
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'hE1) begin fails++; $display("FAIL seed0_refill got=%b/%02h exp=1/E1", rng_if.rnd_valid, rng_if.rnd); end
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    step();
    seed_load = 1'b0;
    checks++; if (state_out !== 16'h1234 || lockup !== 1'b0 || rng_if.rnd_valid !== 1'b0) begin fails++; $display("FAIL seed1234 got=%04h/%b/%b exp=1234/0/0", state_out, lockup, rng_if.rnd_valid); end
    step();
    checks++; if (state_out !== 16'h2469 || rng_if.rnd !== 8'h34 || rng_if.rnd_valid !== 1'b1) begin fails++; $display("FAIL seed1234_next got=%04h/%02h/%b exp=2469/34/1", state_out, rng_if.rnd, rng_if.rnd_valid); end
  endtask

  task automatic test_enable_freeze();
    do_reset(8'd0, 1'b1);
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'hE1) begin fails++; $display("FAIL en_first got=%b/%02h exp=1/E1", rng_if.rnd_valid, rng_if.rnd); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rng_if.rnd_valid !== 1'b0) begin fails++; $display("FAIL en_off_valid[%0d] got=%b exp=0", i, rng_if.rnd_valid); end
      checks++; if (state_out !== 16'h59C3) begin fails++; $display("FAIL en_off_state[%0d] got=%04h exp=59C3", i, state_out); end
    end
    en = 1'b1;
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || rng_if.rnd !== 8'hC3 || state_out !== 16'hB387) begin fails++; $display("FAIL en_resume got=%b/%02h/%04h exp=1/C3/B387", rng_if.rnd_valid, rng_if.rnd, state_out); end
  endtask

  task automatic test_async_reset();
    do_reset(8'd0, 1'b0);
    step();
    step();
    checks++; if (rng_if.rnd_valid !== 1'b1 || state_out !== 16'hB387) begin fails++; $display("FAIL arst_pre got=%b/%04h exp=1/B387", rng_if.rnd_valid, state_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rng_if.rnd_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got=%b exp=0", rng_if.rnd_valid); end
    checks++; if (rng_if.rnd !== 8'h00) begin fails++; $display("FAIL arst_rnd got=%02h exp=00", rng_if.rnd); end
    checks++; if (state_out !== 16'hACE1) begin fails++; $display("FAIL arst_state got=%04h exp=ACE1", state_out); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    seq[0]  = 16'hACE1; seq[1]  = 16'h59C3; seq[2]  = 16'hB387; seq[3]  = 16'h670F;
    seq[4]  = 16'hCE1E; seq[5]  = 16'h9C3C; seq[6]  = 16'h3879; seq[7]  = 16'h70F2;
    seq[8]  = 16'hE1E4; seq[9]  = 16'hC3C8; seq[10] = 16'h8791; seq[11] = 16'h0F22;
    seq[12] = 16'h1E45; seq[13] = 16'h3C8A; seq[14] = 16'h7915; seq[15] = 16'hF22A;
    seq[16] = 16'hE455;
    rst_n            = 1'b0;
    en               = 1'b1;
    seed_load        = 1'b0;
    seed_in          = 16'h0000;
    rng_if.range_in  = 8'd0;
    rng_if.rnd_ready = 1'b0;

    test_reset();
    test_full_range();
    test_bounded_range();
    test_backpressure();
    test_seed_load();
    test_enable_freeze();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
